// File: rtl/fifo_rd_packetizer.sv
// rtl/fifo_rd_packetizer.sv - pops the dual-clock FIFO read port and emits length-framed packets on a valid/ready stream
module fifo_rd_packetizer #(
    parameter int DSIZE = 8,
    parameter int LENW  = 8,
    parameter int PCNTW = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             enable,
    input  logic [LENW-1:0]  pkt_len,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic [PCNTW-1:0] pkt_count
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [LENW-1:0]  len, wcnt, len_load;
    logic [DSIZE-1:0] h_data, t_data;
    logic             h_last, t_last;
    logic [1:0]       buf_cnt;
    logic             push, pop, push_last, start;

    assign len_load  = (pkt_len == '0) ? LENW'(1) : pkt_len;
    assign push      = rinc;
    assign push_last = (wcnt == len - LENW'(1));
    assign pop       = m_valid & m_ready;
    assign start     = ((state == IDLE) || (state == DONE)) && enable;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = h_data;
    assign m_last  = h_last;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = STREAM;
            STREAM:  if (push && push_last) state_nxt = DRAIN;
            DRAIN:   if (pop && h_last) state_nxt = DONE;
            default: state_nxt = enable ? STREAM : IDLE;
        endcase
    end

    // Pop decision uses only registered state and rempty, never m_ready.
    always_comb begin
        rinc = (state == STREAM) && !rempty && (buf_cnt != 2'd2);
        busy = (state != IDLE);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            len       <= '0;
            wcnt      <= '0;
            pkt_count <= '0;
        end else begin
            if (start) begin
                len  <= len_load;
                wcnt <= '0;
            end
            if (push) begin
                wcnt <= push_last ? '0 : wcnt + LENW'(1);
            end
            if (state == DONE) begin
                pkt_count <= pkt_count + PCNTW'(1);
            end
        end
    end

    // Two-entry skid buffer: head drives the stream, tail absorbs one stalled word.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            buf_cnt <= 2'd0;
            h_data  <= '0;
            h_last  <= 1'b0;
            t_data  <= '0;
            t_last  <= 1'b0;
        end else begin
            case (buf_cnt)
                2'd0: begin
                    if (push) begin
                        h_data  <= rdata;
                        h_last  <= push_last;
                        buf_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        h_data <= rdata;
                        h_last <= push_last;
                    end else if (push) begin
                        t_data  <= rdata;
                        t_last  <= push_last;
                        buf_cnt <= 2'd2;
                    end else if (pop) begin
                        buf_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        h_data  <= t_data;
                        h_last  <= t_last;
                        buf_cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
